// File: rtl/instruction_decode.sv
// MIPS ID stage: instruction decode, 32x32 register file and immediate extension.
// Optional macro DECODE_BYPASS_EN makes the register file write-through for same-cycle reads.
module instruction_decode (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] Instruction,
  input  logic [4:0]  RegDestSelected_WB,
  input  logic [31:0] RegWriteData_WB,
  input  logic        RegWrite_WB,
  output logic        PCSel,
  output logic        RegDst,
  output logic        ALUSrc0,
  output logic [1:0]  ALUSrc1,
  output logic        R_Enable,
  output logic        W_Enable,
  output logic [1:0]  R_Width,
  output logic [1:0]  W_Width,
  output logic        MemToReg,
  output logic        RegWrite,
  output logic [4:0]  BranchSel,
  output logic [31:0] Reg_Data1,
  output logic [31:0] Reg_Data2,
  output logic [31:0] Imm32b
);

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_REGIMM = 6'b000001, OP_J    = 6'b000010,
                         OP_JAL   = 6'b000011, OP_BEQ    = 6'b000100, OP_BNE  = 6'b000101,
                         OP_BLEZ  = 6'b000110, OP_BGTZ   = 6'b000111, OP_ADDI = 6'b001000,
                         OP_ADDIU = 6'b001001, OP_SLTI   = 6'b001010, OP_SLTIU= 6'b001011,
                         OP_ANDI  = 6'b001100, OP_ORI    = 6'b001101, OP_XORI = 6'b001110,
                         OP_LUI   = 6'b001111, OP_MUL    = 6'b011100, OP_LB   = 6'b100000,
                         OP_LH    = 6'b100001, OP_LW     = 6'b100011, OP_SB   = 6'b101000,
                         OP_SH    = 6'b101001, OP_SW     = 6'b101011;

  localparam logic [5:0] FN_SLL = 6'b000000, FN_SRL = 6'b000010, FN_SRA  = 6'b000011,
                         FN_JR  = 6'b001000, FN_ADD = 6'b100000, FN_ADDU = 6'b100001,
                         FN_SUB = 6'b100010, FN_AND = 6'b100100, FN_OR   = 6'b100101,
                         FN_XOR = 6'b100110, FN_NOR = 6'b100111, FN_SLT  = 6'b101010,
                         FN_SLTU= 6'b101011, FN_MUL = 6'b000010;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt;
  logic [15:0] imm16;

  assign opcode = Instruction[31:26];
  assign rs     = Instruction[25:21];
  assign rt     = Instruction[20:16];
  assign imm16  = Instruction[15:0];
  assign funct  = Instruction[5:0];

  logic [31:0] regs [32];

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (RegWrite_WB && (RegDestSelected_WB != 5'd0)) begin
      regs[RegDestSelected_WB] <= RegWriteData_WB;
    end
  end

  logic [31:0] rd1, rd2;

  always_comb begin
    rd1 = (rs == 5'd0) ? 32'h0 : regs[rs];
    rd2 = (rt == 5'd0) ? 32'h0 : regs[rt];
`ifdef DECODE_BYPASS_EN
    // Forward the WB data when it targets the register being read this cycle.
    if (RegWrite_WB && (RegDestSelected_WB != 5'd0) && (RegDestSelected_WB == rs)) rd1 = RegWriteData_WB;
    if (RegWrite_WB && (RegDestSelected_WB != 5'd0) && (RegDestSelected_WB == rt)) rd2 = RegWriteData_WB;
`endif
  end

  logic        pc_sel, reg_dst, alu_src0, r_en, w_en, mem_to_reg, reg_write;
  logic [1:0]  alu_src1, r_width, w_width;
  logic [4:0]  branch_sel;
  logic [31:0] imm32;

  always_comb begin
    pc_sel     = 1'b0;
    reg_dst    = 1'b0;
    alu_src0   = 1'b0;
    alu_src1   = 2'b00;
    r_en       = 1'b0;
    w_en       = 1'b0;
    r_width    = 2'b00;
    w_width    = 2'b00;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    branch_sel = 5'd0;
    case (opcode)
      OP_RTYPE: begin
        // The all-zero word would otherwise decode as sll $0,$0,0; it is a true NOP.
        if (Instruction != 32'h0) begin
          case (funct)
            FN_ADD, FN_ADDU, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_XOR, FN_SLT, FN_SLTU: begin
              reg_dst = 1'b1; reg_write = 1'b1;
            end
            FN_SLL, FN_SRL, FN_SRA: begin
              reg_dst = 1'b1; reg_write = 1'b1; alu_src0 = 1'b1;
            end
            FN_JR: begin
              pc_sel = 1'b1; branch_sel = 5'd9;
            end
            default: ;
          endcase
        end
      end
      OP_MUL: begin
        if (funct == FN_MUL) begin
          reg_dst = 1'b1; reg_write = 1'b1;
        end
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        reg_write = 1'b1; alu_src1 = 2'b01;
      end
      OP_LW, OP_LH, OP_LB: begin
        r_en = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1; alu_src1 = 2'b01;
        r_width = (opcode == OP_LW) ? 2'b00 : (opcode == OP_LH) ? 2'b01 : 2'b10;
      end
      OP_SW, OP_SH, OP_SB: begin
        w_en = 1'b1; alu_src1 = 2'b01;
        w_width = (opcode == OP_SW) ? 2'b00 : (opcode == OP_SH) ? 2'b01 : 2'b10;
      end
      OP_BEQ:  begin pc_sel = 1'b1; branch_sel = 5'd1; end
      OP_BNE:  begin pc_sel = 1'b1; branch_sel = 5'd2; end
      OP_BGTZ: begin pc_sel = 1'b1; branch_sel = 5'd3; end
      OP_BLEZ: begin pc_sel = 1'b1; branch_sel = 5'd4; end
      OP_REGIMM: begin
        if (rt == 5'd0) begin pc_sel = 1'b1; branch_sel = 5'd5; end
        else if (rt == 5'd1) begin pc_sel = 1'b1; branch_sel = 5'd6; end
      end
      OP_J:   begin pc_sel = 1'b1; branch_sel = 5'd7; end
      OP_JAL: begin pc_sel = 1'b1; branch_sel = 5'd8; reg_write = 1'b1; end
      default: ;
    endcase

    case (opcode)
      OP_ANDI, OP_ORI, OP_XORI: imm32 = {16'h0000, imm16};
      OP_LUI:                   imm32 = {imm16, 16'h0000};
      default:                  imm32 = {{16{imm16[15]}}, imm16};
    endcase
  end

  // Reset held low blanks every output, data included.
  always_comb begin
    PCSel     = Reset & pc_sel;
    RegDst    = Reset & reg_dst;
    ALUSrc0   = Reset & alu_src0;
    ALUSrc1   = Reset ? alu_src1 : 2'b00;
    R_Enable  = Reset & r_en;
    W_Enable  = Reset & w_en;
    R_Width   = Reset ? r_width : 2'b00;
    W_Width   = Reset ? w_width : 2'b00;
    MemToReg  = Reset & mem_to_reg;
    RegWrite  = Reset & reg_write;
    BranchSel = Reset ? branch_sel : 5'd0;
    Reg_Data1 = Reset ? rd1 : 32'h0;
    Reg_Data2 = Reset ? rd2 : 32'h0;
    Imm32b    = Reset ? imm32 : 32'h0;
  end

endmodule

// File: tb/tb_instruction_decode.sv
// Bench for instruction_decode: decode vector table with scoreboard, plus register-file sequences.
module tb_instruction_decode;

  logic        Clock, Reset;
  logic [31:0] Instruction;
  logic [4:0]  RegDestSelected_WB;
  logic [31:0] RegWriteData_WB;
  logic        RegWrite_WB;
  logic        PCSel, RegDst, ALUSrc0, R_Enable, W_Enable, MemToReg, RegWrite;
  logic [1:0]  ALUSrc1, R_Width, W_Width;
  logic [4:0]  BranchSel;
  logic [31:0] Reg_Data1, Reg_Data2, Imm32b;

  instruction_decode dut (
    .Clock(Clock), .Reset(Reset), .Instruction(Instruction),
    .RegDestSelected_WB(RegDestSelected_WB), .RegWriteData_WB(RegWriteData_WB),
    .RegWrite_WB(RegWrite_WB), .PCSel(PCSel), .RegDst(RegDst), .ALUSrc0(ALUSrc0),
    .ALUSrc1(ALUSrc1), .R_Enable(R_Enable), .W_Enable(W_Enable), .R_Width(R_Width),
    .W_Width(W_Width), .MemToReg(MemToReg), .RegWrite(RegWrite), .BranchSel(BranchSel),
    .Reg_Data1(Reg_Data1), .Reg_Data2(Reg_Data2), .Imm32b(Imm32b)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [31:0] instr;
    logic [17:0] ctrl;
    logic [31:0] imm;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [17:0] ctrl;
    logic [31:0] imm;
    logic [31:0] d1;
    logic [31:0] d2;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  logic [31:0] shadow [32];
  int          checks = 0;
  int          errors = 0;
  logic [17:0] act_ctrl;

  assign act_ctrl = {PCSel, RegDst, ALUSrc0, ALUSrc1, R_Enable, W_Enable,
                     R_Width, W_Width, MemToReg, RegWrite, BranchSel};

  function automatic logic [17:0] mk(input logic pc, input logic rd, input logic a0,
                                     input logic [1:0] a1, input logic re, input logic we,
                                     input logic [1:0] rw, input logic [1:0] ww,
                                     input logic m2r, input logic rgw, input logic [4:0] bs);
    return {pc, rd, a0, a1, re, we, rw, ww, m2r, rgw, bs};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [31:0] instr, input logic [17:0] ctrl, input logic [31:0] imm);
    vec_t v;
    v.instr = instr; v.ctrl = ctrl; v.imm = imm;
    vecs.push_back(v);
  endtask

  task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
    @(posedge Clock); #1;
    RegDestSelected_WB = addr; RegWriteData_WB = data; RegWrite_WB = 1'b1;
    @(posedge Clock); #1;
    RegWrite_WB = 1'b0;
    if (addr != 5'd0) shadow[addr] = data;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {14'h0, act_ctrl}, 32'h0);
    check({tag, "_d1"}, Reg_Data1, 32'h0);
    check({tag, "_d2"}, Reg_Data2, 32'h0);
    check({tag, "_imm"}, Imm32b, 32'h0);
  endtask

  logic [17:0] c_r, c_sh, c_i, c_nul;

  initial begin
    for (int i = 0; i < 32; i++) shadow[i] = 32'h0;
    c_r   = mk(0,1,0,2'd0,0,0,2'd0,2'd0,0,1,5'd0);
    c_sh  = mk(0,1,1,2'd0,0,0,2'd0,2'd0,0,1,5'd0);
    c_i   = mk(0,0,0,2'd1,0,0,2'd0,2'd0,0,1,5'd0);
    c_nul = 18'h0;
    add_vec(32'h00000000, c_nul, 32'h00000000);
    add_vec(32'h00A01820, c_r,   32'h00001820);
    add_vec(32'h00221822, c_r,   32'h00001822);
    add_vec(32'h00222025, c_r,   32'h00002025);
    add_vec(32'h0022202A, c_r,   32'h0000202A);
    add_vec(32'h00031100, c_sh,  32'h00001100);
    add_vec(32'h00031042, c_sh,  32'h00001042);
    add_vec(32'h00031043, c_sh,  32'h00001043);
    add_vec(32'h03E00008, mk(1,0,0,2'd0,0,0,2'd0,2'd0,0,0,5'd9), 32'h00000008);
    add_vec(32'h0022203F, c_nul, 32'h0000203F);
    add_vec(32'h70222002, c_r,   32'h00002002);
    add_vec(32'h70222003, c_nul, 32'h00002003);
    add_vec(32'h2001FFFF, c_i,   32'hFFFFFFFF);
    add_vec(32'h24017FFF, c_i,   32'h00007FFF);
    add_vec(32'h28018000, c_i,   32'hFFFF8000);
    add_vec(32'h2C01FFF0, c_i,   32'hFFFFFFF0);
    add_vec(32'h3001FFFF, c_i,   32'h0000FFFF);
    add_vec(32'h34018000, c_i,   32'h00008000);
    add_vec(32'h38018001, c_i,   32'h00008001);
    add_vec(32'h3C011234, c_i,   32'h12340000);
    add_vec(32'h8CA20008, mk(0,0,0,2'd1,1,0,2'd0,2'd0,1,1,5'd0), 32'h00000008);
    add_vec(32'h84A2FFFC, mk(0,0,0,2'd1,1,0,2'd1,2'd0,1,1,5'd0), 32'hFFFFFFFC);
    add_vec(32'h80A20001, mk(0,0,0,2'd1,1,0,2'd2,2'd0,1,1,5'd0), 32'h00000001);
    add_vec(32'hACA20004, mk(0,0,0,2'd1,0,1,2'd0,2'd0,0,0,5'd0), 32'h00000004);
    add_vec(32'hA4A20002, mk(0,0,0,2'd1,0,1,2'd0,2'd1,0,0,5'd0), 32'h00000002);
    add_vec(32'hA0A20003, mk(0,0,0,2'd1,0,1,2'd0,2'd2,0,0,5'd0), 32'h00000003);
    add_vec(32'h10220003, mk(1,0,0,2'd0,0,0,2'd0,2'd0,0,0,5'd1), 32'h00000003);
    add_vec(32'h14220003, mk(1,0,0,2'd0,0,0,2'd0,2'd0,0,0,5'd2), 32'h00000003);
    add_vec(32'h1C200005, mk(1,0,0,2'd0,0,0,2'd0,2'd0,0,0,5'd3), 32'h00000005);
    add_vec(32'h18200005, mk(1,0,0,2'd0,0,0,2'd0,2'd0,0,0,5'd4), 32'h00000005);
    add_vec(32'h0420FFFE, mk(1,0,0,2'd0,0,0,2'd0,2'd0,0,0,5'd5), 32'hFFFFFFFE);
    add_vec(32'h0421FFFE, mk(1,0,0,2'd0,0,0,2'd0,2'd0,0,0,5'd6), 32'hFFFFFFFE);
    add_vec(32'h0422FFFE, c_nul, 32'hFFFFFFFE);
    add_vec(32'h08000010, mk(1,0,0,2'd0,0,0,2'd0,2'd0,0,0,5'd7), 32'h00000010);
    add_vec(32'h0C000010, mk(1,0,0,2'd0,0,0,2'd0,2'd0,0,1,5'd8), 32'h00000010);
    add_vec(32'hFC000000, c_nul, 32'h00000000);

    // Reset held low for two edges, with a WB write that reset must override
    Reset = 1'b0; Instruction = 32'h0C000010;
    RegDestSelected_WB = 5'd5; RegWriteData_WB = 32'h55555555; RegWrite_WB = 1'b1;
    @(posedge Clock); @(posedge Clock);
    @(negedge Clock);
    check_all_zero("in_reset");
    @(posedge Clock); #1;
    Reset = 1'b1; Instruction = 32'h0; RegWrite_WB = 1'b0;
    @(negedge Clock);
    check_all_zero("after_reset");
    Instruction = 32'h00A01820;
    @(negedge Clock);
    check("reset_blocks_wb", Reg_Data1, 32'h0);

    // Basic write then read of $5
    wb_write(5'd5, 32'hDEADBEEF);
    @(negedge Clock);
    check("add_rd1", Reg_Data1, 32'hDEADBEEF);
    check("add_ctrl", {14'h0, act_ctrl}, {14'h0, c_r});

    wb_write(5'd1, 32'h11111111);
    wb_write(5'd2, 32'h2222A222);
    wb_write(5'd3, 32'h80000003);
    wb_write(5'd31, 32'h0040001C);

    // Decode table through the scoreboard
    foreach (vecs[k]) begin
      exp_t e;
      @(posedge Clock); #1;
      Instruction = vecs[k].instr;
      e.instr = vecs[k].instr; e.ctrl = vecs[k].ctrl; e.imm = vecs[k].imm;
      e.d1 = shadow[vecs[k].instr[25:21]];
      e.d2 = shadow[vecs[k].instr[20:16]];
      sb.push_back(e);
      @(negedge Clock);
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty at vector %0d", k);
      end else begin
        e = sb.pop_front();
        check($sformatf("ctrl_%08h", e.instr), {14'h0, act_ctrl}, {14'h0, e.ctrl});
        check($sformatf("imm_%08h", e.instr), Imm32b, e.imm);
        check($sformatf("rd1_%08h", e.instr), Reg_Data1, e.d1);
        check($sformatf("rd2_%08h", e.instr), Reg_Data2, e.d2);
      end
    end

    // Writes to $0 are discarded, including any same-cycle forwarding
    @(posedge Clock); #1;
    Instruction = 32'h34018000;
    RegDestSelected_WB = 5'd0; RegWriteData_WB = 32'h1; RegWrite_WB = 1'b1;
    @(negedge Clock);
    check("r0_same_cycle", Reg_Data1, 32'h0);
    @(posedge Clock); #1;
    RegWrite_WB = 1'b0;
    @(negedge Clock);
    check("r0_after_edge", Reg_Data1, 32'h0);

    // Same-cycle write/read of $7
    wb_write(5'd7, 32'h0BADF00D);
    @(posedge Clock); #1;
    Instruction = 32'h00E71820;
    RegDestSelected_WB = 5'd7; RegWriteData_WB = 32'h77770007; RegWrite_WB = 1'b1;
    @(negedge Clock);
`ifdef DECODE_BYPASS_EN
    check("r7_bypass_rd1", Reg_Data1, 32'h77770007);
    check("r7_bypass_rd2", Reg_Data2, 32'h77770007);
`else
    check("r7_old_rd1", Reg_Data1, 32'h0BADF00D);
    check("r7_old_rd2", Reg_Data2, 32'h0BADF00D);
`endif
    @(posedge Clock); #1;
    RegWrite_WB = 1'b0;
    @(negedge Clock);
    check("r7_new_rd1", Reg_Data1, 32'h77770007);
    check("r7_new_rd2", Reg_Data2, 32'h77770007);

    // Reset clears the stored registers
    @(posedge Clock); #1;
    Reset = 1'b0; Instruction = 32'h00A71820;
    @(negedge Clock);
    check_all_zero("reset_again");
    @(posedge Clock); #1;
    Reset = 1'b1;
    @(negedge Clock);
    check("cleared_r5", Reg_Data1, 32'h0);
    check("cleared_r7", Reg_Data2, 32'h0);
    check("post_reset_ctrl", {14'h0, act_ctrl}, {14'h0, c_r});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
